// File: rtl/mcs4_bus_master.sv
// MCS-4 bus initiator: sequences SYNC/A1..X3, fetches the instruction byte and runs the I/O side-channel.
// Optional I/O behaviour (cm_rom, SRC, WRR, RDR) is enabled by defining MCS4_MASTER_IO_EN.

package mcs4;
    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;
    localparam logic [3:0] WRR = 4'h2;
    localparam logic [3:0] RDR = 4'hA;
endpackage

module mcs4_bus_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [11:0] cmd_pc,
    input  logic [3:0]  cmd_acc,
    input  logic [7:0]  cmd_src,
    output logic        sync,
    output logic        cm_rom,
    output logic        cl_rom,
    input  logic        cl_req,
    input  logic [3:0]  dbus_in,
    output logic [3:0]  dbus_out,
    output logic        rsp_valid,
    output logic [7:0]  rsp_instr,
    output logic [3:0]  rsp_rdata,
    output logic        rsp_io
);

    localparam logic [3:0] IO_OPR  = 4'hE;
    localparam logic [3:0] SRC_OPR = 4'h2;

`ifdef MCS4_MASTER_IO_EN
    localparam logic IO_EN = 1'b1;
`else
    localparam logic IO_EN = 1'b0;
`endif

    // Bus phases sit in the upper half of the encoding, in instr_cyc_t order.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0000,
        S_SYNC = 4'b0001,
        S_A1   = {1'b1, mcs4::A1},
        S_A2   = {1'b1, mcs4::A2},
        S_A3   = {1'b1, mcs4::A3},
        S_M1   = {1'b1, mcs4::M1},
        S_M2   = {1'b1, mcs4::M2},
        S_X1   = {1'b1, mcs4::X1},
        S_X2   = {1'b1, mcs4::X2},
        S_X3   = {1'b1, mcs4::X3}
    } state_t;

    state_t      state_q, state_d;
    logic        ready_en_q, ready_en_d;
    logic        sync_q, sync_d;
    logic        cl_q, cl_d;
    logic        cm_q, cm_d;
    logic [3:0]  dbus_q, dbus_d;
    logic [11:0] pend_pc_q, pend_pc_d, act_pc_q, act_pc_d;
    logic [3:0]  pend_acc_q, pend_acc_d, act_acc_q, act_acc_d;
    logic [7:0]  pend_src_q, pend_src_d, act_src_q, act_src_d;
    logic [3:0]  opr_q, opr_d, opa_q, opa_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_instr_q, rsp_instr_d;
    logic [3:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_io_q, rsp_io_d;

    logic cmd_ready_s, accept_s, is_io_s, is_src_s, is_wrr_s, is_rdr_s;

    // Command handshake and opcode decode of the captured instruction.
    always_comb begin
        cmd_ready_s = ready_en_q && ((state_q == S_IDLE) || (state_q == S_X2));
        accept_s    = cmd_valid && cmd_ready_s;
        is_io_s     = IO_EN && (opr_q == IO_OPR);
        is_src_s    = IO_EN && (opr_q == SRC_OPR) && opa_q[0];
        is_wrr_s    = is_io_s && (opa_q == mcs4::WRR);
        is_rdr_s    = is_io_s && (opa_q == mcs4::RDR);
    end

    // Next-state logic; X3 chains straight into A1 when a command was taken in X2.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept_s ? S_SYNC : S_IDLE;
            S_SYNC:  state_d = S_A1;
            S_A1:    state_d = S_A2;
            S_A2:    state_d = S_A3;
            S_A3:    state_d = S_M1;
            S_M1:    state_d = S_M2;
            S_M2:    state_d = S_X1;
            S_X1:    state_d = S_X2;
            S_X2:    state_d = S_X3;
            S_X3:    state_d = sync_q ? S_A1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, computed for the state being entered.
    always_comb begin
        ready_en_d  = 1'b1;
        sync_d      = accept_s;
        cl_d        = cl_req;
        pend_pc_d   = pend_pc_q;
        pend_acc_d  = pend_acc_q;
        pend_src_d  = pend_src_q;
        act_pc_d    = act_pc_q;
        act_acc_d   = act_acc_q;
        act_src_d   = act_src_q;
        opr_d       = opr_q;
        opa_d       = opa_q;
        rsp_valid_d = 1'b0;
        rsp_instr_d = rsp_instr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_io_d    = rsp_io_q;
        dbus_d      = 4'h0;
        cm_d        = 1'b0;

        if (accept_s) begin
            pend_pc_d  = cmd_pc;
            pend_acc_d = cmd_acc;
            pend_src_d = cmd_src;
        end else begin
            pend_pc_d  = pend_pc_q;
        end

        if (sync_q) begin
            act_pc_d  = pend_pc_q;
            act_acc_d = pend_acc_q;
            act_src_d = pend_src_q;
        end else begin
            act_pc_d  = act_pc_q;
        end

        if (state_q == S_M1) begin
            opr_d = dbus_in;
        end else if (state_q == S_M2) begin
            opa_d = dbus_in;
        end else begin
            opr_d = opr_q;
        end

        if (state_q == S_X2) begin
            rsp_valid_d = 1'b1;
            rsp_instr_d = {opr_q, opa_q};
            rsp_rdata_d = is_rdr_s ? dbus_in : 4'h0;
            rsp_io_d    = is_rdr_s;
        end else begin
            rsp_valid_d = 1'b0;
        end

        // Entering A1 the active pc is being loaded this edge, so take it from pending.
        case (state_d)
            S_A1: dbus_d = pend_pc_q[3:0];
            S_A2: dbus_d = act_pc_q[7:4];
            S_A3: dbus_d = act_pc_q[11:8];
            S_M2: cm_d   = IO_EN && (dbus_in == IO_OPR);
            S_X2: begin
                if (is_src_s) begin
                    dbus_d = act_src_q[7:4];
                    cm_d   = 1'b1;
                end else if (is_wrr_s) begin
                    dbus_d = act_acc_q;
                end else begin
                    dbus_d = 4'h0;
                end
            end
            S_X3: dbus_d = is_src_s ? act_src_q[3:0] : 4'h0;
            default: dbus_d = 4'h0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_en_q  <= 1'b0;
            sync_q      <= 1'b0;
            cl_q        <= 1'b0;
            cm_q        <= 1'b0;
            dbus_q      <= 4'h0;
            pend_pc_q   <= 12'h000;
            pend_acc_q  <= 4'h0;
            pend_src_q  <= 8'h00;
            act_pc_q    <= 12'h000;
            act_acc_q   <= 4'h0;
            act_src_q   <= 8'h00;
            opr_q       <= 4'h0;
            opa_q       <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= 8'h00;
            rsp_rdata_q <= 4'h0;
            rsp_io_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= ready_en_d;
            sync_q      <= sync_d;
            cl_q        <= cl_d;
            cm_q        <= cm_d;
            dbus_q      <= dbus_d;
            pend_pc_q   <= pend_pc_d;
            pend_acc_q  <= pend_acc_d;
            pend_src_q  <= pend_src_d;
            act_pc_q    <= act_pc_d;
            act_acc_q   <= act_acc_d;
            act_src_q   <= act_src_d;
            opr_q       <= opr_d;
            opa_q       <= opa_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_io_q    <= rsp_io_d;
        end
    end

    assign cmd_ready = cmd_ready_s;
    assign sync      = sync_q;
    assign cl_rom    = cl_q;
    assign cm_rom    = cm_q;
    assign dbus_out  = dbus_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_instr = rsp_instr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_io    = rsp_io_q;

endmodule

// File: tb/tb_mcs4_bus_master.sv
// Directed bench for mcs4_bus_master with a phase-tracking ROM/IO responder model.
module tb_mcs4_bus_master;

`ifdef MCS4_MASTER_IO_EN
    localparam bit IO = 1'b1;
`else
    localparam bit IO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_pc = 12'h000;
    logic [3:0]  cmd_acc = 4'h0;
    logic [7:0]  cmd_src = 8'h00;
    logic        sync, cm_rom, cl_rom;
    logic        cl_req = 1'b0;
    logic [3:0]  dbus_in, dbus_out;
    logic        rsp_valid, rsp_io;
    logic [7:0]  rsp_instr;
    logic [3:0]  rsp_rdata;

    mcs4_bus_master dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_pc(cmd_pc), .cmd_acc(cmd_acc), .cmd_src(cmd_src), .sync(sync),
        .cm_rom(cm_rom), .cl_rom(cl_rom), .cl_req(cl_req), .dbus_in(dbus_in),
        .dbus_out(dbus_out), .rsp_valid(rsp_valid), .rsp_instr(rsp_instr),
        .rsp_rdata(rsp_rdata), .rsp_io(rsp_io)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: phase 1..8 = A1..X3, restarted by sync.
    int          ph = 0;
    logic [11:0] raddr = 12'h000;
    logic [7:0]  rom [0:4095];
    logic [3:0]  rdr_val = 4'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 ph <= 0;
        else if (sync)              ph <= 1;
        else if (ph != 0 && ph < 8) ph <= ph + 1;
        else                        ph <= 0;
    end

    assign dbus_in = (ph == 4) ? rom[raddr][7:4] :
                     (ph == 5) ? rom[raddr][3:0] :
                     (ph == 7) ? rdr_val : 4'h0;

    int         sync_t[$];
    int         rv_t[$];
    logic [7:0] rv_instr[$];
    logic [3:0] rv_rdata[$];
    logic       rv_io[$];
    int         cm_cnt = 0;
    logic [3:0] dbus_at [1:8];
    logic       cm_at   [1:8];

    always @(negedge clk) begin
        if (sync) sync_t.push_back(cyc);
        if (rsp_valid) begin
            rv_t.push_back(cyc);
            rv_instr.push_back(rsp_instr);
            rv_rdata.push_back(rsp_rdata);
            rv_io.push_back(rsp_io);
        end
        if (cm_rom) cm_cnt = cm_cnt + 1;
        if (ph >= 1 && ph <= 8) begin
            dbus_at[ph] = dbus_out;
            cm_at[ph]   = cm_rom;
        end
        if (ph == 1) raddr[3:0]  = dbus_out;
        if (ph == 2) raddr[7:4]  = dbus_out;
        if (ph == 3) raddr[11:8] = dbus_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        sync_t.delete(); rv_t.delete(); rv_instr.delete(); rv_rdata.delete(); rv_io.delete();
        cm_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            dbus_at[i] = 4'hF;
            cm_at[i]   = 1'b1;
        end
    endtask

    // Present a command and hold it until accepted; acc_c is the accepting cycle.
    task automatic issue(input logic [11:0] pc, input logic [3:0] acc, input logic [7:0] src,
                         output int acc_c);
        int n;
        cmd_pc = pc; cmd_acc = acc; cmd_src = src; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 40) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            vec_cnt++; err_cnt++;
            $display("FAIL issue_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        acc_c = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(2);
        vec_cnt++;
        if ({sync, cm_rom, cl_rom, dbus_out, rsp_valid, rsp_instr, rsp_rdata, rsp_io, cmd_ready} !== 22'h0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h required 0",
                     {sync, cm_rom, cl_rom, dbus_out, rsp_valid, rsp_instr, rsp_rdata, rsp_io, cmd_ready});
        end
        rst_n = 1'b1;
        vec_cnt++;
        if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL ready_before_edge: got %b required 0", cmd_ready); end
        tick();
        vec_cnt++;
        if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL ready_after_reset: got %b required 1", cmd_ready); end
    endtask

    task automatic test_fetch();
        int a;
        clear_logs();
        issue(12'h1A5, 4'h0, 8'h00, a);
        wait_cycles(12);
        vec_cnt++;
        if (sync_t.size() != 1 || sync_t[0] != a + 1) begin
            err_cnt++; $display("FAIL fetch_sync: count %0d first %0d required at %0d", sync_t.size(), sync_t.size() ? sync_t[0] : -1, a + 1);
        end
        vec_cnt++;
        if ({dbus_at[1], dbus_at[2], dbus_at[3]} !== 12'h5A1) begin
            err_cnt++; $display("FAIL fetch_addr: got %h required 5a1", {dbus_at[1], dbus_at[2], dbus_at[3]});
        end
        vec_cnt++;
        if (rv_t.size() != 1 || rv_t[0] != a + 9 || rv_instr[0] !== 8'h3C) begin
            err_cnt++; $display("FAIL fetch_rsp: count %0d at %0d instr %h required 1 at %0d instr 3c",
                                rv_t.size(), rv_t.size() ? rv_t[0] : -1, rv_t.size() ? rv_instr[0] : 8'hxx, a + 9);
        end
        vec_cnt++;
        if (cm_cnt != 0) begin err_cnt++; $display("FAIL fetch_cm: cm_rom high %0d cycles required 0", cm_cnt); end
        vec_cnt++;
        if (rsp_valid !== 1'b0 || rsp_instr !== 8'h3C) begin
            err_cnt++; $display("FAIL fetch_hold: valid %b instr %h required 0 3c", rsp_valid, rsp_instr);
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        rom[12'h010] = 8'h11; rom[12'h020] = 8'h52; rom[12'h030] = 8'hA7;
        clear_logs();
        issue(12'h010, 4'h0, 8'h00, a0);
        issue(12'h020, 4'h0, 8'h00, a1);
        issue(12'h030, 4'h0, 8'h00, a2);
        wait_cycles(12);
        vec_cnt++;
        if (a1 - a0 != 8 || a2 - a1 != 8) begin
            err_cnt++; $display("FAIL b2b_accept: gaps %0d %0d required 8 8", a1 - a0, a2 - a1);
        end
        vec_cnt++;
        if (sync_t.size() != 3 || sync_t[1] - sync_t[0] != 8 || sync_t[2] - sync_t[1] != 8) begin
            err_cnt++; $display("FAIL b2b_sync: count %0d required 3 with period 8", sync_t.size());
        end
        vec_cnt++;
        if (rv_t.size() != 3 || rv_t[1] - rv_t[0] != 8 || rv_t[2] - rv_t[1] != 8 || rv_t[0] != a0 + 9) begin
            err_cnt++; $display("FAIL b2b_rsp: count %0d required 3 spaced 8 from %0d", rv_t.size(), a0 + 9);
        end
        vec_cnt++;
        if (rv_instr.size() != 3 || {rv_instr[0], rv_instr[1], rv_instr[2]} !== 24'h1152A7) begin
            err_cnt++; $display("FAIL b2b_instr: got %0d entries required 11 52 a7", rv_instr.size());
        end
    endtask

    task automatic test_src();
        int a;
        rom[12'h2C0] = 8'h23;
        clear_logs();
        issue(12'h2C0, 4'h0, 8'h4B, a);
        wait_cycles(12);
        vec_cnt++;
        if (dbus_at[7] !== (IO ? 4'h4 : 4'h0) || cm_at[7] !== IO) begin
            err_cnt++; $display("FAIL src_x2: dbus %h cm %b required %h %b", dbus_at[7], cm_at[7], IO ? 4'h4 : 4'h0, IO);
        end
        vec_cnt++;
        if (dbus_at[8] !== (IO ? 4'hB : 4'h0) || cm_at[8] !== 1'b0) begin
            err_cnt++; $display("FAIL src_x3: dbus %h cm %b required %h 0", dbus_at[8], cm_at[8], IO ? 4'hB : 4'h0);
        end
        vec_cnt++;
        if (cm_at[5] !== 1'b0 || rv_instr.size() != 1 || rv_instr[0] !== 8'h23) begin
            err_cnt++; $display("FAIL src_m2: cm %b responses %0d required 0 and one 23", cm_at[5], rv_instr.size());
        end
    endtask

    task automatic test_wrr();
        int a0, a1;
        rom[12'h300] = 8'h21; rom[12'h301] = 8'hE2;
        clear_logs();
        issue(12'h300, 4'h0, 8'h41, a0);
        issue(12'h301, 4'h6, 8'h00, a1);
        wait_cycles(12);
        vec_cnt++;
        if (cm_at[5] !== IO) begin err_cnt++; $display("FAIL wrr_m2_cm: got %b required %b", cm_at[5], IO); end
        vec_cnt++;
        if (dbus_at[7] !== (IO ? 4'h6 : 4'h0) || cm_at[7] !== 1'b0) begin
            err_cnt++; $display("FAIL wrr_x2: dbus %h cm %b required %h 0", dbus_at[7], cm_at[7], IO ? 4'h6 : 4'h0);
        end
        vec_cnt++;
        if (dbus_at[8] !== 4'h0 || rv_io.size() != 2 || rv_io[1] !== 1'b0) begin
            err_cnt++; $display("FAIL wrr_x3: dbus %h responses %0d required 0 and two", dbus_at[8], rv_io.size());
        end
    endtask

    task automatic test_rdr();
        int a;
        rom[12'h0F0] = 8'hEA;
        rdr_val = 4'h9;
        clear_logs();
        issue(12'h0F0, 4'h3, 8'h00, a);
        wait_cycles(12);
        rdr_val = 4'h0;
        vec_cnt++;
        if (rv_t.size() != 1 || rv_instr[0] !== 8'hEA || rv_rdata[0] !== (IO ? 4'h9 : 4'h0) || rv_io[0] !== IO) begin
            err_cnt++; $display("FAIL rdr_rsp: count %0d required 1 with instr ea rdata %h io %b",
                                rv_t.size(), IO ? 4'h9 : 4'h0, IO);
        end
        vec_cnt++;
        if (rsp_rdata !== (IO ? 4'h9 : 4'h0) || rsp_io !== IO || dbus_at[7] !== 4'h0) begin
            err_cnt++; $display("FAIL rdr_hold: rdata %h io %b dbus %h required %h %b 0", rsp_rdata, rsp_io, dbus_at[7], IO ? 4'h9 : 4'h0, IO);
        end
        rdr_val = 4'h7;
        clear_logs();
        issue(12'h1A5, 4'h0, 8'h00, a);
        wait_cycles(12);
        rdr_val = 4'h0;
        vec_cnt++;
        if (rsp_rdata !== 4'h0 || rsp_io !== 1'b0 || rsp_instr !== 8'h3C) begin
            err_cnt++; $display("FAIL rdr_clear: rdata %h io %b instr %h required 0 0 3c", rsp_rdata, rsp_io, rsp_instr);
        end
    endtask

    task automatic test_cl();
        cl_req = 1'b1;
        vec_cnt++;
        if (cl_rom !== 1'b0) begin err_cnt++; $display("FAIL cl_idle: got %b required 0", cl_rom); end
        tick();
        cl_req = 1'b0;
        vec_cnt++;
        if (cl_rom !== 1'b1) begin err_cnt++; $display("FAIL cl_pulse: got %b required 1", cl_rom); end
        tick();
        vec_cnt++;
        if (cl_rom !== 1'b0) begin err_cnt++; $display("FAIL cl_end: got %b required 0", cl_rom); end
        cl_req = 1'b1;
        wait_cycles(2);
        vec_cnt++;
        if (cl_rom !== 1'b1) begin err_cnt++; $display("FAIL cl_cont: got %b required 1", cl_rom); end
        cl_req = 1'b0;
        wait_cycles(2);
        vec_cnt++;
        if (cl_rom !== 1'b0) begin err_cnt++; $display("FAIL cl_cont_end: got %b required 0", cl_rom); end
    endtask

    task automatic test_reset_mid();
        int a, n;
        clear_logs();
        issue(12'h1A5, 4'h0, 8'h00, a);
        n = 0;
        while (ph != 4 && n < 20) begin tick(); n++; end
        vec_cnt++;
        if (ph != 4) begin err_cnt++; $display("FAIL mid_reach_m1: phase %0d required 4", ph); end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({sync, cm_rom, cl_rom, dbus_out, rsp_valid, rsp_instr, rsp_rdata, rsp_io, cmd_ready} !== 22'h0) begin
            err_cnt++; $display("FAIL mid_reset_outputs: got %h required 0",
                                {sync, cm_rom, cl_rom, dbus_out, rsp_valid, rsp_instr, rsp_rdata, rsp_io, cmd_ready});
        end
        tick();
        rst_n = 1'b1;
        tick();
        vec_cnt++;
        if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL mid_idle: cmd_ready %b required 1", cmd_ready); end
        clear_logs();
        issue(12'h2C0, 4'h0, 8'h4B, a);
        wait_cycles(12);
        vec_cnt++;
        if (sync_t.size() != 1 || sync_t[0] != a + 1 || rv_t.size() != 1 || rv_t[0] != a + 9 || rv_instr[0] !== 8'h23) begin
            err_cnt++; $display("FAIL mid_restart: sync %0d rsp %0d required one each at %0d and %0d with instr 23",
                                sync_t.size(), rv_t.size(), a + 1, a + 9);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h1A5] = 8'h3C;
        clear_logs();
        test_reset();
        test_fetch();
        test_back_to_back();
        test_src();
        test_wrr();
        test_rdr();
        test_cl();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
